// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the execute-to-commit writeback arbiter.
// Build option WB_OLDEST_FIRST_EN selects ROB-age priority instead of round-robin.
package wb_arbiter_pkg;

   localparam int unsigned WB_ROB_IDX_W = 4;
   localparam int unsigned WB_IDX_W     = 3;

   localparam int unsigned WB_REQ_ALU0 = 0;
   localparam int unsigned WB_REQ_ALU1 = 1;
   localparam int unsigned WB_REQ_MDU  = 2;
   localparam int unsigned WB_REQ_LSU  = 3;

   typedef struct packed {
      logic                    valid;
      logic [WB_ROB_IDX_W-1:0] rob_entry_num;
      logic                    rd_we;
      logic [4:0]              rd_addr;
      logic [31:0]             result;
      logic                    exception;
   } execute_to_commit_bus_t;

   typedef struct packed {
      logic                g1_v;
      logic                g2_v;
      logic [WB_IDX_W-1:0] g1;
      logic [WB_IDX_W-1:0] g2;
   } wb_grant_t;

   function automatic logic [WB_IDX_W-1:0] wb_idx_inc(input logic [WB_IDX_W-1:0] idx,
                                                     input int unsigned num);
      logic [WB_IDX_W-1:0] nxt;
      nxt = idx + WB_IDX_W'(1);
      if (32'(idx) == num - 1) begin
         nxt = '0;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/wb_arbiter_pick2.sv
// Combinational two-of-N picker: round-robin from a base pointer, or oldest ROB age
// first when WB_OLDEST_FIRST_EN is defined.
module wb_pick2
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
`ifdef WB_OLDEST_FIRST_EN
   , parameter int unsigned ROB_IDX_W = WB_ROB_IDX_W
`endif
) (
   input  logic [NUM_REQ-1:0]   i_valid,
`ifdef WB_OLDEST_FIRST_EN
   input  logic [ROB_IDX_W-1:0] i_age [NUM_REQ],
`else
   input  logic [WB_IDX_W-1:0]  i_rr_ptr,
`endif
   output wb_grant_t            o_grant
);

   // Each entry gets a priority key; the two smallest keys win, ties to the lower index.
   int unsigned w_key [NUM_REQ];
   int unsigned w_best1;
   int unsigned w_best2;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
`ifdef WB_OLDEST_FIRST_EN
         w_key[i] = 32'(i_age[i]);
`else
         // Distance from the round-robin base, walking upward with wrap.
         if (32'(i) >= 32'(i_rr_ptr)) begin
            w_key[i] = 32'(i) - 32'(i_rr_ptr);
         end else begin
            w_key[i] = 32'(i) + NUM_REQ - 32'(i_rr_ptr);
         end
`endif
      end
   end

   always_comb begin
      o_grant = '0;
      w_best1 = '0;
      w_best2 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_valid[i]) begin
            if (!o_grant.g1_v || (w_key[i] < w_best1)) begin
               if (o_grant.g1_v) begin
                  o_grant.g2_v = 1'b1;
                  o_grant.g2   = o_grant.g1;
                  w_best2      = w_best1;
               end
               o_grant.g1_v = 1'b1;
               o_grant.g1   = WB_IDX_W'(i);
               w_best1      = w_key[i];
            end else if (!o_grant.g2_v || (w_key[i] < w_best2)) begin
               o_grant.g2_v = 1'b1;
               o_grant.g2   = WB_IDX_W'(i);
               w_best2      = w_key[i];
            end
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding entry per execute pipe, up to two registered grants
// per cycle into commit. WB_OLDEST_FIRST_EN switches grant priority to ROB age.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ROB_IDX_W = WB_ROB_IDX_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_flush,
   input  logic [ROB_IDX_W-1:0]   i_rob_head,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  execute_to_commit_bus_t i_req_bus [NUM_REQ],
   output logic [NUM_REQ-1:0]     o_req_ready,
   output execute_to_commit_bus_t o_execute_to_commit_bus1,
   output execute_to_commit_bus_t o_execute_to_commit_bus2,
   output logic                   o_wb_busy
);

   logic [NUM_REQ-1:0]     r_hold_valid;
   execute_to_commit_bus_t r_hold_bus [NUM_REQ];
   logic [NUM_REQ-1:0]     w_hold_valid_nxt;
   execute_to_commit_bus_t w_hold_bus_nxt [NUM_REQ];

   wb_grant_t              w_grant;
   logic [NUM_REQ-1:0]     w_grant_vec;
   execute_to_commit_bus_t w_bus1;
   execute_to_commit_bus_t w_bus2;

`ifdef WB_OLDEST_FIRST_EN
   logic [ROB_IDX_W-1:0] w_age [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_age[i] = ROB_IDX_W'(r_hold_bus[i].rob_entry_num) - i_rob_head;
      end
   end

   wb_pick2 #(
      .NUM_REQ   (NUM_REQ),
      .ROB_IDX_W (ROB_IDX_W)
   ) u_pick2 (
      .i_valid (r_hold_valid),
      .i_age   (w_age),
      .o_grant (w_grant)
   );
`else
   logic [WB_IDX_W-1:0] r_rr_ptr;
   logic [WB_IDX_W-1:0] w_last;
   logic                w_unused_rob_head;

   assign w_unused_rob_head = ^i_rob_head;
   assign w_last            = w_grant.g2_v ? w_grant.g2 : w_grant.g1;

   wb_pick2 #(
      .NUM_REQ (NUM_REQ)
   ) u_pick2 (
      .i_valid  (r_hold_valid),
      .i_rr_ptr (r_rr_ptr),
      .o_grant  (w_grant)
   );

   // Grants made in a flush cycle are discarded, so they must not move the pointer either.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr <= '0;
      end else if (!i_flush && w_grant.g1_v) begin
         r_rr_ptr <= wb_idx_inc(w_last, NUM_REQ);
      end
   end
`endif

   always_comb begin
      w_bus1 = '0;
      w_bus2 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_grant_vec[i] = (w_grant.g1_v && (w_grant.g1 == WB_IDX_W'(i))) ||
                          (w_grant.g2_v && (w_grant.g2 == WB_IDX_W'(i)));
         if (w_grant.g1_v && (w_grant.g1 == WB_IDX_W'(i))) begin
            w_bus1       = r_hold_bus[i];
            w_bus1.valid = 1'b1;
         end
         if (w_grant.g2_v && (w_grant.g2 == WB_IDX_W'(i))) begin
            w_bus2       = r_hold_bus[i];
            w_bus2.valid = 1'b1;
         end
      end
   end

   // A granted entry may be refilled in the same cycle, giving one result per cycle per pipe.
   assign o_req_ready = {NUM_REQ{!i_flush}} & (~r_hold_valid | w_grant_vec);
   assign o_wb_busy   = |r_hold_valid;

   always_comb begin
      w_hold_valid_nxt = r_hold_valid;
      w_hold_bus_nxt   = r_hold_bus;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_flush) begin
            w_hold_valid_nxt[i] = 1'b0;
         end else if (i_req_valid[i] && o_req_ready[i]) begin
            w_hold_valid_nxt[i] = 1'b1;
            w_hold_bus_nxt[i]   = i_req_bus[i];
         end else if (w_grant_vec[i]) begin
            w_hold_valid_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold_valid             <= '0;
         o_execute_to_commit_bus1 <= '0;
         o_execute_to_commit_bus2 <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_hold_bus[i] <= '0;
         end
      end else begin
         r_hold_valid <= w_hold_valid_nxt;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_hold_bus[i] <= w_hold_bus_nxt[i];
         end
         if (i_flush) begin
            o_execute_to_commit_bus1 <= '0;
            o_execute_to_commit_bus2 <= '0;
         end else begin
            o_execute_to_commit_bus1 <= w_bus1;
            o_execute_to_commit_bus2 <= w_bus2;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic, checked
// against a priority-list reference model.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned RW = WB_ROB_IDX_W;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   flush = 1'b0;
   logic [RW-1:0]          rob_head = '0;
   logic [N-1:0]           req_valid = '0;
   execute_to_commit_bus_t req_bus [N];
   logic [N-1:0]           req_ready;
   execute_to_commit_bus_t bus1;
   execute_to_commit_bus_t bus2;
   logic                   busy;

   always #5 clk = ~clk;

   wb_arbiter #(
      .NUM_REQ   (N),
      .ROB_IDX_W (RW)
   ) dut (
      .i_clk                    (clk),
      .i_rst_n                  (rst_n),
      .i_flush                  (flush),
      .i_rob_head               (rob_head),
      .i_req_valid              (req_valid),
      .i_req_bus                (req_bus),
      .o_req_ready              (req_ready),
      .o_execute_to_commit_bus1 (bus1),
      .o_execute_to_commit_bus2 (bus2),
      .o_wb_busy                (busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit                     m_hv [N];
   execute_to_commit_bus_t m_hb [N];
   int                     m_rr;
   execute_to_commit_bus_t m_o1;
   execute_to_commit_bus_t m_o2;
   int                     m_g1;
   int                     m_g2;
   logic [N-1:0]           m_ready;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic execute_to_commit_bus_t rand_bus(input int rob);
      execute_to_commit_bus_t b;
      b.valid         = 1'($urandom);
      b.rob_entry_num = RW'(rob);
      b.rd_we         = 1'($urandom);
      b.rd_addr       = 5'($urandom);
      b.result        = $urandom;
      b.exception     = 1'($urandom);
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      m_rr = 0;
      m_o1 = '0;
      m_o2 = '0;
   endtask

   // Build the priority order of held entries, then take the first two.
   task automatic model_pick();
      int order[$];
      logic [RW-1:0] age;
      m_g1 = -1;
      m_g2 = -1;
`ifdef WB_OLDEST_FIRST_EN
      for (int a = 0; a < (1 << RW); a++) begin
         for (int i = 0; i < N; i++) begin
            age = m_hb[i].rob_entry_num - rob_head;
            if (m_hv[i] && (int'(age) == a)) order.push_back(i);
         end
      end
`else
      age = '0;
      for (int k = 0; k < N; k++) begin
         if (m_hv[(m_rr + k) % N]) order.push_back((m_rr + k) % N);
      end
`endif
      if (order.size() > 0) m_g1 = order[0];
      if (order.size() > 1) m_g2 = order[1];
      for (int i = 0; i < N; i++) begin
         m_ready[i] = !flush && (!m_hv[i] || (i == m_g1) || (i == m_g2));
      end
   endtask

   task automatic model_edge();
      if (flush) begin
         for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
         m_o1 = '0;
         m_o2 = '0;
      end else begin
         m_o1 = '0;
         m_o2 = '0;
         if (m_g1 >= 0) begin
            m_o1       = m_hb[m_g1];
            m_o1.valid = 1'b1;
            m_hv[m_g1] = 1'b0;
            m_rr       = (m_g1 + 1) % N;
         end
         if (m_g2 >= 0) begin
            m_o2       = m_hb[m_g2];
            m_o2.valid = 1'b1;
            m_hv[m_g2] = 1'b0;
            m_rr       = (m_g2 + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && m_ready[i]) begin
               m_hv[i] = 1'b1;
               m_hb[i] = req_bus[i];
            end
         end
      end
   endtask

   function automatic logic model_busy();
      logic b;
      b = 1'b0;
      for (int i = 0; i < N; i++) b = b | m_hv[i];
      return b;
   endfunction

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic step();
      #3;
      model_pick();
      check("req_ready", 64'(req_ready), 64'(m_ready));
      @(posedge clk);
      model_edge();
      #1;
      check("bus1", 64'(bus1), 64'(m_o1));
      check("bus2", 64'(bus2), 64'(m_o2));
      check("wb_busy", 64'(busy), 64'(model_busy()));
   endtask

   task automatic randomize_buses();
      for (int i = 0; i < N; i++) req_bus[i] = rand_bus(int'($urandom_range(0, 15)));
   endtask

   initial begin
      for (int i = 0; i < N; i++) req_bus[i] = '0;
      model_reset();

      // Reset state
      #12;
      check("rst_bus1", 64'(bus1), 64'(0));
      check("rst_bus2", 64'(bus2), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      #8 rst_n = 1'b1;
      #6;

      // Single pipe, 2-cycle latency
      req_valid = 4'b0001;
      req_bus[WB_REQ_ALU0] = rand_bus(5);
      step();
      req_valid = '0;
      step();
      check("lat_valid", 64'(bus1.valid), 64'(1));
      check("lat_rob", 64'(bus1.rob_entry_num), 64'(5));
      check("lat_bus2_valid", 64'(bus2.valid), 64'(0));
      step();
      step();

      // All pipes streaming
      req_valid = '1;
      for (int c = 0; c < 8; c++) begin
         randomize_buses();
         step();
      end
      req_valid = '0;
      repeat (4) step();

      // Wrap: park the pointer at 3, then pipes 3 and 0
      req_valid = 4'b0100;
      req_bus[WB_REQ_MDU] = rand_bus(8);
      step();
      req_valid = '0;
      step();
      step();
      req_valid = 4'b1001;
      req_bus[WB_REQ_LSU]  = rand_bus(9);
      req_bus[WB_REQ_ALU0] = rand_bus(2);
      step();
      req_valid = '0;
      step();
`ifndef WB_OLDEST_FIRST_EN
      check("wrap_bus1_rob", 64'(bus1.rob_entry_num), 64'(9));
      check("wrap_bus2_rob", 64'(bus2.rob_entry_num), 64'(2));
`endif
      step();

      // Flush with everything held
      req_valid = '1;
      for (int c = 0; c < 4; c++) begin
         randomize_buses();
         step();
      end
      flush = 1'b1;
      step();
      check("flush_busy", 64'(busy), 64'(0));
      check("flush_bus1_valid", 64'(bus1.valid), 64'(0));
      flush = 1'b0;
      req_valid = '0;
      repeat (3) step();

`ifdef WB_OLDEST_FIRST_EN
      rob_head = RW'(14);
      req_valid = '1;
      req_bus[0] = rand_bus(1);
      req_bus[1] = rand_bus(15);
      req_bus[2] = rand_bus(3);
      req_bus[3] = rand_bus(14);
      step();
      req_valid = '0;
      repeat (3) step();
`endif

      // Asynchronous reset between edges
      req_valid = '1;
      randomize_buses();
      step();
      step();
      #2 rst_n = 1'b0;
      req_valid = '0;
      #1;
      model_reset();
      check("arst_bus1", 64'(bus1), 64'(0));
      check("arst_bus2", 64'(bus2), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_ready", 64'(req_ready), 64'({N{1'b1}}));
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 4'b1000;
      req_bus[WB_REQ_LSU] = rand_bus(7);
      step();
      req_valid = '0;
      step();
      check("arst_lat_valid", 64'(bus1.valid), 64'(1));
      check("arst_lat_rob", 64'(bus1.rob_entry_num), 64'(7));
      step();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         flush     = ($urandom_range(0, 15) == 0);
         rob_head  = RW'($urandom);
         randomize_buses();
         step();
      end
      flush = 1'b0;
      req_valid = '0;
      repeat (4) step();
      check("drain_busy", 64'(busy), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
